// File: rtl/uart_rx_deser.sv
// 16x-oversampling UART receiver: recovers 8N1 frames and strobes good bytes into the RX FIFO.
// Define UART_RX_PARITY_EN for 8E1/8O1 frames with a PARITY state and a live parity_err.
module uart_rx_deser #(
  parameter int unsigned DIVISOR     = 27,
  parameter int unsigned OSR         = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  input  logic       rxff,
  input  logic       parity_odd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       parity_err,
  output logic       busy
);

  localparam logic [15:0] TickLast = 16'(DIVISOR - 1);
  localparam logic [3:0]  SampMid  = 4'(OSR / 2 - 1);
  localparam logic [3:0]  SampLast = 4'(OSR - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_e;

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic [15:0]              tick_cnt_q, tick_cnt_d;
  logic [3:0]               samp_cnt_q, samp_cnt_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [7:0]               shift_q, shift_d;
  logic [7:0]               data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     ferr_q, ferr_d;
  logic                     oerr_q, oerr_d;
  logic                     rx_s;
  logic                     tick;
  logic                     mid_bit;

`ifdef UART_RX_PARITY_EN
  logic par_bit_q, par_bit_d;
  logic perr_q, perr_d;
  logic parity_bad;

  // Received parity bit must equal XOR of the data bits, inverted for odd parity.
  assign parity_bad = ((^shift_q) ^ parity_odd) != par_bit_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  // Synchronizer reloads the idle level on reset so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_serial};
    end
  end

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign tick    = (tick_cnt_q == TickLast);
  assign mid_bit = tick && (samp_cnt_q == SampLast);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
    samp_cnt_d = tick ? samp_cnt_q + 4'd1 : samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    oerr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d  = par_bit_q;
    perr_d     = 1'b0;
`endif

    case (state_q)
      StIdle: begin
        // Timing is frozen here so each frame aligns to its own falling edge.
        tick_cnt_d = 16'd0;
        samp_cnt_d = 4'd0;
        bit_cnt_d  = 3'd0;
        if (!rx_s) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (tick && (samp_cnt_q == SampMid)) begin
          if (rx_s) begin
            state_d = StIdle;
          end else begin
            samp_cnt_d = 4'd0;
            bit_cnt_d  = 3'd0;
            state_d    = StData;
          end
        end
      end

      StData: begin
        if (mid_bit) begin
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (mid_bit) begin
          par_bit_d = rx_s;
          state_d   = StStop;
        end
      end
`endif

      StStop: begin
        if (mid_bit) begin
          if (!rx_s) begin
            ferr_d  = 1'b1;
            state_d = StBreak;
`ifdef UART_RX_PARITY_EN
          end else if (parity_bad) begin
            perr_d  = 1'b1;
            state_d = StIdle;
`endif
          end else if (rxff) begin
            oerr_d  = 1'b1;
            state_d = StIdle;
          end else begin
            valid_d = 1'b1;
            data_d  = shift_q;
            state_d = StIdle;
          end
        end
      end

      // A held-low line must rise before another start bit is considered.
      StBreak: begin
        if (rx_s) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      tick_cnt_q <= 16'd0;
      samp_cnt_q <= 4'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      oerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      oerr_q     <= oerr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_bit_q <= par_bit_d;
      perr_q    <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed and randomized frames against a frame-level model of the UART receiver.
module tb_uart_rx_deser;

  localparam int unsigned Div    = 4;
  localparam int          BitClk = 16 * Div;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_serial = 1'b1;
  logic       rxff = 1'b0;
  logic       parity_odd = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_valid = 0, n_ferr = 0, n_perr = 0, n_oerr = 0, n_multi = 0;
  int b_valid = 0, b_ferr = 0, b_perr = 0, b_oerr = 0;
  logic [7:0] data_q[$];
  int         vtime_q[$];

  uart_rx_deser #(
    .DIVISOR    (Div),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_serial  (rx_serial),
    .rxff       (rxff),
    .parity_odd (parity_odd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Pulse recorder, sampled away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) begin
        n_valid++;
        data_q.push_back(rx_data);
        vtime_q.push_back(cyc);
      end
      if (frame_err)   n_ferr++;
      if (parity_err)  n_perr++;
      if (overrun_err) n_oerr++;
      if ((32'(rx_valid) + 32'(frame_err) + 32'(parity_err) + 32'(overrun_err)) > 1) n_multi++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(logic v);
    rx_serial = v;
    wait_clk(BitClk);
  endtask

  task automatic send_frame(logic [7:0] b, logic stop, logic par, output int t0);
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par === 1'bx) $display("note: parity bit undefined");
`endif
    drive_bit(stop);
  endtask

  // Expected pulse deltas since the last call; rebaselines afterwards.
  task automatic expect_pulses(string tag, int ev, int ef, int ep, int eo);
    check({tag, "_valid"}, n_valid - b_valid, ev);
    check({tag, "_ferr"},  n_ferr - b_ferr,   ef);
    check({tag, "_perr"},  n_perr - b_perr,   ep);
    check({tag, "_oerr"},  n_oerr - b_oerr,   eo);
    b_valid = n_valid;
    b_ferr  = n_ferr;
    b_perr  = n_perr;
    b_oerr  = n_oerr;
  endtask

  // Frame outcome from the receiver rules: 0 write, 1 framing, 2 parity, 3 overrun.
  function automatic int model_kind(logic [7:0] b, logic stop, logic par, logic full, logic odd);
    logic par_ok;
`ifdef UART_RX_PARITY_EN
    par_ok = ((^b) ^ odd) == par;
`else
    par_ok = 1'b1;
    if (par === 1'bx && odd === 1'bx) par_ok = 1'b1;
`endif
    if (!stop) return 1;
    if (!par_ok) return 2;
    if (full) return 3;
    return 0;
  endfunction

  initial begin
    int t0;
    int t1;
    int lat;
    int kind;
    logic [7:0] b;
    logic stop;
    logic par;

    wait_clk(5);
    check("reset_rx_valid",    32'(rx_valid),    0);
    check("reset_rx_data",     32'(rx_data),     0);
    check("reset_frame_err",   32'(frame_err),   0);
    check("reset_overrun_err", 32'(overrun_err), 0);
    check("reset_parity_err",  32'(parity_err),  0);
    check("reset_busy",        32'(busy),        0);
    reset = 1'b0;
    wait_clk(5);

    // Good 8N1 byte
    send_frame(8'hA5, 1'b1, 1'b0, t0);
    wait_clk(2 * BitClk);
    expect_pulses("a5", 1, 0, 0, 0);
    check("a5_data", 32'(data_q[$]), 32'hA5);
    lat = vtime_q[$] - t0;
    check($sformatf("a5_latency_in_606_616_lat%0d", lat), 32'(lat >= 606 && lat <= 616), 1);
    check("a5_busy_after", 32'(busy), 0);
    check("a5_data_held", 32'(rx_data), 32'hA5);

    // False start glitch
    rx_serial = 1'b0;
    wait_clk(10);
    check("glitch_busy_in", 32'(busy), 1);
    wait_clk(10);
    rx_serial = 1'b1;
    wait_clk(8 * Div + 20);
    check("glitch_busy_out", 32'(busy), 0);
    expect_pulses("glitch", 0, 0, 0, 0);

    // Framing error followed by held-low break
    send_frame(8'h3C, 1'b0, 1'b0, t0);
    wait_clk(3 * BitClk);
    check("break_busy_low", 32'(busy), 1);
    expect_pulses("break", 0, 1, 0, 0);
    rx_serial = 1'b1;
    wait_clk(10);
    check("break_busy_rise", 32'(busy), 0);
    wait_clk(BitClk);
    expect_pulses("break_after", 0, 0, 0, 0);

    // Overrun then recovery
    rxff = 1'b1;
    send_frame(8'h81, 1'b1, 1'b0, t0);
    wait_clk(BitClk);
    expect_pulses("ovr", 0, 0, 0, 1);
    rxff = 1'b0;
    send_frame(8'h7E, 1'b1, 1'b0, t0);
    wait_clk(BitClk);
    expect_pulses("ovr_next", 1, 0, 0, 0);
    check("ovr_next_data", 32'(data_q[$]), 32'h7E);

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1, 1'b0, t0);
    send_frame(8'hFF, 1'b1, 1'b1, t1);
    wait_clk(BitClk);
    expect_pulses("b2b", 2, 0, 0, 0);
    check("b2b_first",   32'(data_q[$-1]), 32'h00);
    check("b2b_second",  32'(data_q[$]),   32'hFF);
    check("b2b_spacing", vtime_q[$] - vtime_q[$-1], 640);
    check("b2b_drive_gap", t1 - t0, 640);

    // Reset in the middle of a third frame
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    wait_clk(20);
    reset = 1'b1;
    wait_clk(3);
    rx_serial = 1'b1;
    wait_clk(1);
    check("midrst_rx_data", 32'(rx_data), 0);
    check("midrst_busy",    32'(busy),    0);
    check("midrst_valid",   32'(rx_valid), 0);
    reset = 1'b0;
    wait_clk(10 * BitClk);
    expect_pulses("midrst", 0, 0, 0, 0);
    check("midrst_data_after", 32'(rx_data), 0);

`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    send_frame(8'h03, 1'b1, 1'b0, t0);
    wait_clk(BitClk);
    expect_pulses("par_good", 1, 0, 0, 0);
    check("par_good_data", 32'(data_q[$]), 32'h03);
    send_frame(8'h03, 1'b1, 1'b1, t0);
    wait_clk(BitClk);
    expect_pulses("par_bad", 0, 0, 1, 0);
`endif

    // Randomized frames against the frame model
    for (int i = 0; i < 8; i++) begin
      b          = 8'($urandom_range(0, 255));
      stop       = ($urandom_range(0, 3) != 0);
      par        = 1'($urandom_range(0, 1));
      rxff       = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      kind = model_kind(b, stop, par, rxff, parity_odd);
      send_frame(b, stop, par, t0);
      rx_serial = 1'b1;
      wait_clk(2 * BitClk);
      expect_pulses($sformatf("rand%0d", i), 32'(kind == 0), 32'(kind == 1),
                    32'(kind == 2), 32'(kind == 3));
      if (kind == 0) check($sformatf("rand%0d_data", i), 32'(data_q[$]), 32'(b));
      check($sformatf("rand%0d_idle", i), 32'(busy), 0);
    end
    rxff = 1'b0;

    check("one_pulse_per_cycle", n_multi, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
